// File: rtl/deconv_pkg.sv
// Shared constants and helpers for the deconv result arbiter slice.
package deconv_pkg;

  localparam int N_LANES   = 4;
  localparam int PIX_WIDTH = 16;
  localparam int N_PIX_OUT = 4;
  localparam int COL_WIDTH = 2 * PIX_WIDTH * N_PIX_OUT;
  localparam int CNT_WIDTH = 16;
  localparam int LANE_W    = $clog2(N_LANES);

  // Lane index reached by stepping 'off' places forward from 'base', wrapping at N_LANES.
  function automatic logic [LANE_W-1:0] rr_index(input logic [LANE_W-1:0] base,
                                                 input int unsigned       off);
    int unsigned sum;
    sum = (32'(base) + off) % N_LANES;
    return sum[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/deconv_result_arbiter_rr_grant_sel.sv
// Combinational round-robin selector: first requester at or after ptr wins.
module rr_grant_sel
  import deconv_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [LANE_W-1:0]  ptr,
  output logic [N_LANES-1:0] gnt_oh,
  output logic [LANE_W-1:0]  gnt_idx,
  output logic               any_grant
);

  logic [LANE_W-1:0] idx;

  always_comb begin
    idx       = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    gnt_oh    = '0;
    // Walk from the farthest offset back to ptr so the nearest requester is written last.
    for (int i = N_LANES - 1; i >= 0; i--) begin
      idx = rr_index(ptr, unsigned'(i));
      if (req[idx]) begin
        gnt_idx   = idx;
        any_grant = 1'b1;
      end
    end
    gnt_oh[gnt_idx] = any_grant;
  end

endmodule

// File: rtl/deconv_result_arbiter.sv
// Merges four deconv lane result strobes into one tagged valid/ready stream.
// Optional statistics counters are enabled with macro DECONV_ARB_STATS_EN.
module deconv_result_arbiter
  import deconv_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic [CNT_WIDTH-1:0]         i_cols_per_chnl,
  input  logic [N_LANES-1:0]           i_lane_valid,
  input  logic [N_LANES*COL_WIDTH-1:0] i_lane_data,
  output logic [N_LANES-1:0]           o_lane_busy,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [COL_WIDTH-1:0]         o_data,
  output logic [LANE_W-1:0]            o_lane_id,
  output logic                         o_last,
  output logic [N_LANES-1:0]           o_overflow
`ifdef DECONV_ARB_STATS_EN
  ,
  output logic [31:0]                  o_stall_cycles,
  output logic [31:0]                  o_beat_count
`endif
);

  // Handshake: a beat transfers on an edge where o_valid && i_ready; while o_valid is
  // high and i_ready low, o_data/o_lane_id/o_last hold and no new grant is made.

  logic [COL_WIDTH-1:0] hold_data [N_LANES];
  logic [N_LANES-1:0]   hold_full;
  logic [CNT_WIDTH-1:0] col_cnt [N_LANES];
  logic [LANE_W-1:0]    rr_ptr;

  logic                 out_load;
  logic [N_LANES-1:0]   gnt_oh;
  logic [LANE_W-1:0]    gnt_idx;
  logic                 any_grant;
  logic [N_LANES-1:0]   grant_vec;
  logic [CNT_WIDTH-1:0] last_col;
  logic                 gnt_last;

  assign o_lane_busy = hold_full;
  assign out_load    = !o_valid || i_ready;
  assign grant_vec   = gnt_oh & {N_LANES{out_load && any_grant}};
  // A zero column count behaves like one column per channel.
  assign last_col    = (i_cols_per_chnl == '0) ? '0 : i_cols_per_chnl - CNT_WIDTH'(1);
  assign gnt_last    = (col_cnt[gnt_idx] == last_col);

  rr_grant_sel u_sel (
    .req       (hold_full),
    .ptr       (rr_ptr),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_full  <= '0;
      o_overflow <= '0;
      for (int k = 0; k < N_LANES; k++) hold_data[k] <= '0;
    end else if (i_clear) begin
      hold_full  <= '0;
      o_overflow <= '0;
      for (int k = 0; k < N_LANES; k++) hold_data[k] <= '0;
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        // A hold being granted this edge is free to accept the new strobe.
        if (i_lane_valid[k] && (!hold_full[k] || grant_vec[k])) begin
          hold_data[k] <= i_lane_data[k*COL_WIDTH +: COL_WIDTH];
          hold_full[k] <= 1'b1;
        end else if (grant_vec[k]) begin
          hold_full[k] <= 1'b0;
        end
        if (i_lane_valid[k] && hold_full[k] && !grant_vec[k]) o_overflow[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_lane_id <= '0;
      o_last    <= 1'b0;
      rr_ptr    <= '0;
      for (int k = 0; k < N_LANES; k++) col_cnt[k] <= '0;
    end else if (i_clear) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_lane_id <= '0;
      o_last    <= 1'b0;
      rr_ptr    <= '0;
      for (int k = 0; k < N_LANES; k++) col_cnt[k] <= '0;
    end else if (out_load) begin
      if (any_grant) begin
        o_valid          <= 1'b1;
        o_data           <= hold_data[gnt_idx];
        o_lane_id        <= gnt_idx;
        o_last           <= gnt_last;
        rr_ptr           <= rr_index(gnt_idx, 1);
        col_cnt[gnt_idx] <= gnt_last ? '0 : col_cnt[gnt_idx] + CNT_WIDTH'(1);
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef DECONV_ARB_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_beat_count   <= '0;
    end else if (i_clear) begin
      o_stall_cycles <= '0;
      o_beat_count   <= '0;
    end else begin
      if (o_valid && !i_ready && (o_stall_cycles != '1)) o_stall_cycles <= o_stall_cycles + 32'd1;
      if (o_valid && i_ready && (o_beat_count != '1)) o_beat_count <= o_beat_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_deconv_result_arbiter.sv
// Randomized and directed bench for deconv_result_arbiter with a scoreboard of expected beats.
module tb_deconv_result_arbiter;
  import deconv_pkg::*;

  localparam int EW = COL_WIDTH + LANE_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                         i_clear;
  logic [CNT_WIDTH-1:0]         cols;
  logic [N_LANES-1:0]           lane_valid;
  logic [N_LANES*COL_WIDTH-1:0] lane_data;
  logic [N_LANES-1:0]           o_lane_busy;
  logic                         o_valid;
  logic                         i_ready;
  logic [COL_WIDTH-1:0]         o_data;
  logic [LANE_W-1:0]            o_lane_id;
  logic                         o_last;
  logic [N_LANES-1:0]           o_overflow;
`ifdef DECONV_ARB_STATS_EN
  logic [31:0]                  o_stall_cycles;
  logic [31:0]                  o_beat_count;
`endif

  deconv_result_arbiter dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_clear         (i_clear),
    .i_cols_per_chnl (cols),
    .i_lane_valid    (lane_valid),
    .i_lane_data     (lane_data),
    .o_lane_busy     (o_lane_busy),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_data          (o_data),
    .o_lane_id       (o_lane_id),
    .o_last          (o_last),
    .o_overflow      (o_overflow)
`ifdef DECONV_ARB_STATS_EN
    ,
    .o_stall_cycles  (o_stall_cycles),
    .o_beat_count    (o_beat_count)
`endif
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [COL_WIDTH-1:0] act,
                       input logic [COL_WIDTH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [COL_WIDTH-1:0] m_hold [N_LANES];
  logic [N_LANES-1:0]   m_full;
  logic [N_LANES-1:0]   m_ovf;
  int                   m_cnt [N_LANES];
  int                   m_ptr;
  logic                 m_valid;
  logic [COL_WIDTH-1:0] m_data;
  int                   m_id;
  logic                 m_last;

  task automatic model_reset();
    m_full  = '0;
    m_ovf   = '0;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_last  = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      m_hold[k] = '0;
      m_cnt[k]  = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge();
    int g;
    int lim;
    int k;
    if (i_clear) begin
      model_reset();
      return;
    end
    g = -1;
    if (!m_valid || i_ready) begin
      for (int i = 0; i < N_LANES; i++) begin
        k = (m_ptr + i) % N_LANES;
        if (m_full[k] && g < 0) g = k;
      end
      if (g >= 0) begin
        lim = (cols == 0) ? 1 : int'(cols);
        m_last   = (m_cnt[g] + 1 == lim);
        m_cnt[g] = m_last ? 0 : m_cnt[g] + 1;
        m_data   = m_hold[g];
        m_id     = g;
        m_full[g] = 1'b0;
        m_ptr    = (g + 1) % N_LANES;
        m_valid  = 1'b1;
        exp_q.push_back({m_last, LANE_W'(g), m_data});
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int j = 0; j < N_LANES; j++) begin
      if (lane_valid[j]) begin
        if (!m_full[j]) begin
          m_hold[j] = lane_data[j*COL_WIDTH +: COL_WIDTH];
          m_full[j] = 1'b1;
        end else begin
          m_ovf[j] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid", COL_WIDTH'(o_valid), COL_WIDTH'(m_valid));
        check("busy", COL_WIDTH'(o_lane_busy), COL_WIDTH'(m_full));
        check("overflow", COL_WIDTH'(o_overflow), COL_WIDTH'(m_ovf));
        if (m_valid) begin
          check("data", o_data, m_data);
          check("lane_id", COL_WIDTH'(o_lane_id), COL_WIDTH'(m_id));
          check("last", COL_WIDTH'(o_last), COL_WIDTH'(m_last));
        end
        if (o_valid && i_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_beat actual=lane%0d required=no_beat", o_lane_id);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", o_data, e[COL_WIDTH-1:0]);
            check("sb_lane", COL_WIDTH'(o_lane_id), COL_WIDTH'(e[COL_WIDTH +: LANE_W]));
            check("sb_last", COL_WIDTH'(o_last), COL_WIDTH'(e[EW-1]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    lane_valid = '0;
    i_clear    = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [COL_WIDTH-1:0] d);
    lane_data[k*COL_WIDTH +: COL_WIDTH] = d;
    lane_valid[k] = 1'b1;
  endtask

  task automatic rand_data();
    for (int w = 0; w < N_LANES * COL_WIDTH / 32; w++) lane_data[w*32 +: 32] = $urandom();
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n;
    i_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || m_full != '0) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, COL_WIDTH'(o_valid), '0);
    check({name, "_data"}, o_data, '0);
    check({name, "_id"}, COL_WIDTH'(o_lane_id), '0);
    check({name, "_last"}, COL_WIDTH'(o_last), '0);
    check({name, "_busy"}, COL_WIDTH'(o_lane_busy), '0);
    check({name, "_ovf"}, COL_WIDTH'(o_overflow), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [COL_WIDTH-1:0] d1, d2, d3;
    logic [6:0] mask;
    int nb, acc0;

    rst_n = 1'b0; i_clear = 1'b0; cols = 16'd1; lane_valid = '0; lane_data = '0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single lane latency
    d1 = {16{8'hA5}};
    set_lane(2, d1);
    tick();
    check("lat_e0_valid", COL_WIDTH'(o_valid), '0);
    check("lat_e0_busy", COL_WIDTH'(o_lane_busy), COL_WIDTH'(4'b0100));
    tick();
    check("lat_e1_valid", COL_WIDTH'(o_valid), COL_WIDTH'(1));
    check("lat_e1_id", COL_WIDTH'(o_lane_id), COL_WIDTH'(2));
    check("lat_e1_data", o_data, d1);
    tick();
    check("lat_e2_valid", COL_WIDTH'(o_valid), '0);

    // Fairness from pointer 0, then from pointer 1
    do_clear();
    rand_data();
    lane_valid = 4'b1111;
    tick();
    for (int i = 0; i < N_LANES; i++) begin
      tick();
      check("fair0_id", COL_WIDTH'(o_lane_id), COL_WIDTH'(i));
    end
    tick();
    rand_data();
    lane_valid = 4'b0001;
    tick(); tick(); tick();
    rand_data();
    lane_valid = 4'b1111;
    tick();
    for (int i = 0; i < N_LANES; i++) begin
      tick();
      check("fair1_id", COL_WIDTH'(o_lane_id), COL_WIDTH'((i + 1) % N_LANES));
    end
    drain();

    // Backpressure and overflow
    do_clear();
    i_ready = 1'b0;
    d1 = {4{32'h1111_0001}}; d2 = {4{32'h2222_0002}}; d3 = {4{32'h3333_0003}};
    set_lane(1, d1); tick();
    set_lane(1, d2); tick();
    check("bp_valid", COL_WIDTH'(o_valid), COL_WIDTH'(1));
    check("bp_data1", o_data, d1);
    check("bp_busy", COL_WIDTH'(o_lane_busy), COL_WIDTH'(4'b0010));
    set_lane(1, d3); tick();
    check("bp_ovf", COL_WIDTH'(o_overflow), COL_WIDTH'(4'b0010));
    check("bp_hold_stable", o_data, d1);
    tick(); tick();
    check("bp_stall_stable", o_data, d1);
    acc0 = acc_cnt;
    i_ready = 1'b1;
    repeat (4) tick();
    check("bp_beats", COL_WIDTH'(acc_cnt - acc0), COL_WIDTH'(2));

    // Channel framing
    do_clear();
    cols = 16'd3;
    mask = '0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 7) begin rand_data(); lane_valid = 4'b0001; end
      tick();
      if (o_valid && nb < 7) begin mask[nb] = o_last; nb++; end
    end
    check("frame3_beats", COL_WIDTH'(nb), COL_WIDTH'(7));
    check("frame3_last", COL_WIDTH'(mask), COL_WIDTH'(7'b0100100));
    do_clear();
    cols = 16'd0;
    mask = '0; nb = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin rand_data(); lane_valid = 4'b0001; end
      tick();
      if (o_valid && nb < 3) begin mask[nb] = o_last; nb++; end
    end
    check("frame0_last", COL_WIDTH'(mask), COL_WIDTH'(3'b111));

    // Same-cycle capture and grant on lane 3
    do_clear();
    cols = 16'd1;
    i_ready = 1'b0;
    d1 = {4{32'hAAAA_0003}}; d2 = {4{32'hBBBB_0003}}; d3 = {4{32'hCCCC_0003}};
    set_lane(3, d1); tick();
    set_lane(3, d2); tick();
    i_ready = 1'b1;
    set_lane(3, d3); tick();
    check("same_ovf", COL_WIDTH'(o_overflow), '0);
    check("same_busy", COL_WIDTH'(o_lane_busy), COL_WIDTH'(4'b1000));
    check("same_data2", o_data, d2);
    tick();
    check("same_data3", o_data, d3);
    check("same_id", COL_WIDTH'(o_lane_id), COL_WIDTH'(3));
    drain();

    // Clear mid-operation, strobe in clear cycle discarded
    i_ready = 1'b0;
    rand_data(); lane_valid = 4'b1111; tick();
    tick();
    rand_data(); lane_valid = 4'b0010; tick();
    check("pre_clear_valid", COL_WIDTH'(o_valid), COL_WIDTH'(1));
    rand_data(); lane_valid = 4'b0100; i_clear = 1'b1; tick();
    check_zero("clear");

    // Async reset mid-operation
    rand_data(); lane_valid = 4'b1111; tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_ready = 1'b1;

    // Randomized phases
    for (int r = 0; r < 4; r++) begin
      do_clear();
      cols = 16'($urandom_range(0, 4));
      for (int c = 0; c < 200; c++) begin
        rand_data();
        for (int k = 0; k < N_LANES; k++) lane_valid[k] = ($urandom_range(0, 9) < 3);
        i_ready = ($urandom_range(0, 9) < 7);
        tick();
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deconv_result_arbiter.md
Name: deconv_result_arbiter

Overview:
- Collects per-column results from the four deconv sub-cores, which pulse valid independently. Merges them into one valid/ready stream toward the result writer.
- One holding register per lane; lanes are granted round-robin.
- Tags each beat with its lane id and an end-of-channel marker.
- Flags lost results when a lane pulses while its holding register is still occupied.

Parameters:
- N_LANES, 4, number of sub-cores / result lanes.
- PIX_WIDTH, 16, pixel width; results are 2*PIX_WIDTH per output pixel.
- N_PIX_OUT, 4, output pixels per column.
- COL_WIDTH, 2*PIX_WIDTH*N_PIX_OUT, width of one column result.
- CNT_WIDTH, 16, width of the column counters and of the columns-per-channel config.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_clear, in, 1, synchronous soft clear (start of layer).
- i_cols_per_chnl, in, CNT_WIDTH, columns per channel per lane. Must be stable while beats are in flight.
- i_lane_valid, in, N_LANES, one-cycle result strobe per lane.
- i_lane_data, in, N_LANES*COL_WIDTH, lane k occupies [k*COL_WIDTH +: COL_WIDTH].
- o_lane_busy, out, N_LANES, holding register k occupied.
- o_valid, out, 1, output beat valid.
- i_ready, in, 1, downstream accept.
- o_data, out, COL_WIDTH, output column.
- o_lane_id, out, 2 (clog2 N_LANES), source lane of the beat.
- o_last, out, 1, beat is the final column of the channel for that lane.
- o_overflow, out, N_LANES, sticky per-lane lost-result flag.

Behaviour:
- Reset (async, i_rst_n low): all holding registers empty, o_lane_busy=0, o_valid=0, o_data=0, o_lane_id=0, o_last=0, o_overflow=0, column counters=0, round-robin pointer=lane 0.
- i_clear high at an edge: same state as reset. Takes priority over every other event in that cycle; lane strobes in that cycle are discarded.
- Capture: i_lane_valid[k] at an edge with hold k empty loads hold k from lane k's slice and sets it full.
- Overflow, hold k full and not granted that cycle:
  - new data is dropped and the old data is kept;
  - o_overflow[k] sets and stays set until reset or i_clear.
- Simultaneous capture and grant of lane k: hold k takes the new data and stays full; no overflow.
- Output stage is a single register and loads when (!o_valid || i_ready):
  - Search order is pointer, pointer+1, … modulo N_LANES; the first full hold is granted.
  - The granted hold moves to o_data/o_lane_id/o_last with o_valid=1, and the hold is freed in the same edge.
  - The pointer moves to granted+1 (wrap N_LANES-1→0).
  - If no hold is full, o_valid goes to 0.
- Stall: o_valid && !i_ready keeps o_data, o_lane_id and o_last stable. No new grant; holds keep filling.
- Latency:
  - A strobe at edge E0 gives o_valid=1 after edge E1, i.e. 2 cycles minimum.
  - Sustained throughput is one beat per cycle when i_ready=1.
- Column counter per lane advances on each grant of that lane:
  - o_last = (cnt[k] == i_cols_per_chnl-1); on a last beat cnt[k] wraps to 0.
  - i_cols_per_chnl==0 is treated as 1, so o_last is asserted on every beat.
- o_lane_busy is a direct register output so the sub-cores can hold off.
- Lanes never starve: any full hold is granted within N_LANES output loads.

Optional Feature:
- Macro DECONV_ARB_STATS_EN.
- With the macro defined:
  - an extra output o_stall_cycles (32 bits) counts cycles with o_valid && !i_ready;
  - an extra output o_beat_count (32 bits) counts accepted beats;
  - both saturate at all-ones and clear on reset or i_clear.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package deconv_pkg holds:
  - N_LANES, PIX_WIDTH, N_PIX_OUT and the derived COL_WIDTH;
  - the lane-id width constant;
  - a function for round-robin next-index search.
- One sub-module, rr_grant_sel: combinational round-robin selector.
  - Inputs: request vector, pointer.
  - Outputs: grant one-hot, grant index, any_grant.
  - Used by the output stage.

Test Plan:
- Single lane, i_ready=1:
  - lane 2 strobes data 0xA5..A5 at E0 → after E1, o_valid=1, o_lane_id=2, o_data matches; next cycle o_valid=0.
- Fairness:
  - all 4 lanes strobe in the same cycle with i_ready=1 → beats appear on lanes 0,1,2,3 on consecutive cycles;
  - repeat the strobes with the pointer at 1 → order 1,2,3,0.
- Backpressure and overflow:
  - i_ready=0 and lane 1 strobes twice → the first beat is held stable in the output register;
  - the second strobe sits in hold 1 with o_lane_busy[1]=1;
  - a third strobe sets o_overflow[1]=1 and the held data is unchanged;
  - after i_ready=1, exactly 2 beats come out.
- Channel framing:
  - i_cols_per_chnl=3, lane 0 sends 7 columns → o_last on beats 3 and 6 only;
  - with i_cols_per_chnl=0, o_last is set on every beat.
- Same-cycle capture/grant:
  - hold 3 full and granted in the same cycle lane 3 strobes → no overflow; the new data is output next grant.
- Reset and clear mid-operation:
  - assert i_rst_n=0 asynchronously, or i_clear=1, while holds are full and o_valid=1 → all outputs zero immediately (reset) or after the edge (clear);
  - a lane strobe during the i_clear cycle is not captured.
